output_load_sequencer: RTL and testbench
========================================

Name: output_load_sequencer

Overview:
- Sits directly downstream of the PIM output buffer.
- Sequences the load-mode handshake: drives the load enable, the 6-bit load counter and the load-mode select into the buffer, and captures each returned 32-bit word.
- Captured words go into a small FIFO and are delivered to the RISC-V side over a valid/ready read port.
- Replaces firmware-driven, word-by-word load_cnt stepping with a single start command.

Parameters:
- NUM_GROUPS, 32, number of mapping-group words per full load (1..32).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
- LOAD_LAT, 0, cycles from load_en_o high to valid data on buf_data_i (0 or 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle command pulse; accepted only in IDLE.
- mode_i  in  2  load mode sampled with start_i: 1 = read-mode single word; 2/3 = mapping-group load; 0 = illegal.
- abort_i  in  1  cancels the sequence and flushes the FIFO.
- buf_data_i  in  32  word returned by the output buffer.
- load_en_o  out  1  load strobe to the buffer.
- load_cnt_o  out  6  word index presented with load_en_o.
- load_mode_o  out  2  mode held toward the buffer for the whole sequence.
- rdata_o  out  32  FIFO head word.
- rvalid_o  out  1  FIFO not empty.
- rready_i  in  1  consumer accepts rdata_o when rvalid_o && rready_i.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when the last word has been popped.
- err_o  out  1  one-cycle pulse when start_i arrives with mode_i == 0.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- Total words N = 1 for mode 1; N = NUM_GROUPS for modes 2/3.
- States:
  - IDLE:
    - start_i && mode_i != 0 -> latch mode into load_mode_o, clear issue_cnt, go to ISSUE.
    - start_i && mode_i == 0 -> pulse err_o next cycle, stay in IDLE.
  - ISSUE:
    - Issue condition: (fifo_count + inflight) < FIFO_DEPTH.
    - When the condition holds, assert load_en_o for one cycle with load_cnt_o = issue_cnt, then increment issue_cnt.
    - Back-to-back issue is allowed while credit remains.
    - After issuing word N-1 -> go to DRAIN.
  - DRAIN: wait until inflight == 0 and the FIFO is empty, then pulse done_o and go to IDLE.
- Capture timing:
  - LOAD_LAT = 0: buf_data_i is written to the FIFO in the same cycle as load_en_o.
  - LOAD_LAT = 1: written one cycle later, tracked by a 1-bit inflight flag.
- Credit rule: the credit check counts inflight words, so the FIFO never overflows. An overflow is a design error; assert on it in simulation.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- load_mode_o is held from ISSUE entry until return to IDLE, then cleared to 0. The buffer's output mux must stay selected while data is in flight.
- load_cnt_o holds its last value when load_en_o is low; it is cleared on return to IDLE.
- abort_i (any state, highest priority):
  - next cycle state = IDLE, FIFO flushed, inflight cleared, load_en_o = 0;
  - no done_o pulse;
  - a LOAD_LAT = 1 word returning in the abort cycle is discarded.
- start_i while busy_o is ignored; no error pulse.
- Reset mid-sequence behaves like abort but is asynchronous, and all outputs go to 0.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- load_cnt_o is 6 bits wide. Indices never exceed NUM_GROUPS-1, so no wrap occurs.

Test Plan:
- Mode 2, NUM_GROUPS=32, LOAD_LAT=0, rready_i always 1, buf_data_i = 0xA000_0000 + load_cnt:
  - 32 consecutive load_en_o pulses with load_cnt 0..31;
  - rdata_o sequence 0xA000_0000..0xA000_001F;
  - done_o one cycle after the last pop; busy_o low afterwards.
- Mode 1, data 0x1234_5678:
  - exactly one load_en_o with load_cnt_o = 0 and load_mode_o = 1;
  - rdata_o = 0x1234_5678, then done_o.
- Backpressure: mode 3, FIFO_DEPTH=4, rready_i held 0:
  - exactly 4 load_en_o pulses (cnt 0..3), then stall.
  - Raise rready_i for 1 cycle -> cnt 4 issued. All 32 words eventually arrive in order with no loss.
- LOAD_LAT=1 with random rready_i: word order and values still match the index; inflight + count never exceeds 4.
- Abort after 10 words issued with 3 held in the FIFO:
  - next cycle rvalid_o = 0, busy_o = 0, load_mode_o = 0, no done_o.
  - A new start in mode 2 restarts from cnt 0.
- start_i with mode_i = 0 -> single err_o pulse, busy_o stays 0. start_i during busy -> ignored, and the sequence completes normally.

Source files
------------

// File: rtl/output_load_sequencer.sv
// Output load sequencer: steps the PIM output buffer through a load sequence and
// queues the returned words in a small FIFO for the RISC-V read port.
module output_load_sequencer #(
    parameter int NUM_GROUPS = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LOAD_LAT   = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic        abort_i,
    input  logic [31:0] buf_data_i,
    output logic        load_en_o,
    output logic [5:0]  load_cnt_o,
    output logic [1:0]  load_mode_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [5:0]       LAST_GROUP = 6'(NUM_GROUPS - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_OCC  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [5:0]       issue_cnt_q, issue_cnt_d;
    logic             load_en_q, load_en_d;
    logic [5:0]       load_cnt_q, load_cnt_d;
    logic [1:0]       load_mode_q, load_mode_d;
    logic             inflight_q, inflight_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      mem_q [FIFO_DEPTH];

    logic             push;
    logic             pop;
    logic             credit;
    logic             last_word;
    logic [OCC_W-1:0] occupancy;

    always_comb begin
        push     = (LOAD_LAT == 0) ? load_en_q : inflight_q;
        pop      = (count_q != '0) && rready_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (abort_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Credit covers every word already requested but not yet popped, so a push never lands on a full FIFO.
    always_comb begin
        occupancy   = OCC_W'(count_q) + OCC_W'(load_en_q) + OCC_W'(inflight_q);
        credit      = occupancy < DEPTH_OCC;
        last_word   = (load_mode_q == 2'd1) ? (issue_cnt_q == 6'd0) : (issue_cnt_q == LAST_GROUP);
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        load_en_d   = 1'b0;
        load_cnt_d  = load_cnt_q;
        load_mode_d = load_mode_q;
        inflight_d  = (LOAD_LAT == 1) && load_en_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (abort_i) begin
            state_d     = IDLE;
            issue_cnt_d = '0;
            load_cnt_d  = '0;
            load_mode_d = '0;
            inflight_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (mode_i != 2'd0) begin
                            load_mode_d = mode_i;
                            issue_cnt_d = '0;
                            state_d     = ISSUE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (credit) begin
                        load_en_d   = 1'b1;
                        load_cnt_d  = issue_cnt_q;
                        issue_cnt_d = issue_cnt_q + 6'd1;
                        if (last_word) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    // Looking at the next count lets done follow the final pop by one cycle.
                    if ((count_d == '0) && !inflight_d) begin
                        done_d      = 1'b1;
                        state_d     = IDLE;
                        load_mode_d = '0;
                        load_cnt_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            load_en_q   <= 1'b0;
            load_cnt_q  <= '0;
            load_mode_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            load_en_q   <= load_en_d;
            load_cnt_q  <= load_cnt_d;
            load_mode_q <= load_mode_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !abort_i) begin
            mem_q[wr_ptr_q] <= buf_data_i;
        end
    end

    overflow_check: assert property (@(posedge clk_i) disable iff (!rst_ni || abort_i)
        !(push && !pop && (count_q == DEPTH_CNT)));

    assign load_en_o   = load_en_q;
    assign load_cnt_o  = load_cnt_q;
    assign load_mode_o = load_mode_q;
    assign rdata_o     = mem_q[rd_ptr_q];
    assign rvalid_o    = (count_q != '0);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_output_load_sequencer.sv
// Directed bench for output_load_sequencer: one instance with zero load latency,
// one with single-cycle latency; each task drives a scenario and checks it inline.
`timescale 1ns/1ps
module tb_output_load_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start0, abort0, rready0, en0, rvalid0, busy0, done0, err0;
    logic [1:0]  mode0, lmode0;
    logic [5:0]  cnt0;
    logic [31:0] buf0, rdata0;
    logic        start1, abort1, rready1, en1, rvalid1, busy1, done1, err1;
    logic [1:0]  mode1, lmode1;
    logic [5:0]  cnt1;
    logic [31:0] buf1, rdata1;
    logic [31:0] data_base;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [5:0]  en_log0[$];
    logic [1:0]  mode_log0[$];
    logic [31:0] rd_log0[$];
    logic [31:0] rd_log1[$];
    int first_en0, last_en0, last_pop0, done_cyc0, done_cnt0, err_cnt0;
    int issued0, popped0, max_out0;
    int done_cnt1, issued1, popped1, max_out1;

    output_load_sequencer #(.NUM_GROUPS(32), .FIFO_DEPTH(4), .LOAD_LAT(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .mode_i(mode0), .abort_i(abort0),
        .buf_data_i(buf0), .load_en_o(en0), .load_cnt_o(cnt0), .load_mode_o(lmode0),
        .rdata_o(rdata0), .rvalid_o(rvalid0), .rready_i(rready0), .busy_o(busy0),
        .done_o(done0), .err_o(err0)
    );

    output_load_sequencer #(.NUM_GROUPS(32), .FIFO_DEPTH(4), .LOAD_LAT(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .mode_i(mode1), .abort_i(abort1),
        .buf_data_i(buf1), .load_en_o(en1), .load_cnt_o(cnt1), .load_mode_o(lmode1),
        .rdata_o(rdata1), .rvalid_o(rvalid1), .rready_i(rready1), .busy_o(busy1),
        .done_o(done1), .err_o(err1)
    );

    // Buffer models: immediate answer for dut0, one-cycle answer (junk otherwise) for dut1.
    assign buf0 = data_base + {26'd0, cnt0};
    always @(posedge clk) buf1 <= en1 ? (32'hA000_0000 + {26'd0, cnt1}) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (en0) begin
            if (en_log0.size() == 0) first_en0 = cyc;
            last_en0 = cyc;
            en_log0.push_back(cnt0);
            mode_log0.push_back(lmode0);
            issued0++;
        end
        if (rvalid0 && rready0) begin
            rd_log0.push_back(rdata0);
            last_pop0 = cyc;
            popped0++;
        end
        if (done0) begin
            done_cnt0++;
            done_cyc0 = cyc;
        end
        if (err0) err_cnt0++;
        if (issued0 - popped0 > max_out0) max_out0 = issued0 - popped0;
        if (en1) issued1++;
        if (rvalid1 && rready1) begin
            rd_log1.push_back(rdata1);
            popped1++;
        end
        if (done1) done_cnt1++;
        if (issued1 - popped1 > max_out1) max_out1 = issued1 - popped1;
        cyc++;
    end

    task automatic clear_logs;
        en_log0.delete();
        mode_log0.delete();
        rd_log0.delete();
        rd_log1.delete();
        first_en0 = -1; last_en0 = -1; last_pop0 = -1; done_cyc0 = -1;
        done_cnt0 = 0; err_cnt0 = 0; issued0 = 0; popped0 = 0; max_out0 = 0;
        done_cnt1 = 0; issued1 = 0; popped1 = 0; max_out1 = 0;
    endtask

    task automatic start_seq0(input logic [1:0] m);
        @(negedge clk);
        start0 = 1'b1;
        mode0  = m;
        @(negedge clk);
        start0 = 1'b0;
        mode0  = 2'd0;
    endtask

    task automatic wait_idle0(input int budget, output bit timed_out);
        int n = 0;
        while (busy0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        timed_out = busy0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({en0, cnt0, lmode0, rvalid0, busy0, done0, err0} !== 13'd0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl0: got %b expected 0", {en0, cnt0, lmode0, rvalid0, busy0, done0, err0});
        end
        total++;
        if (rdata0 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_rdata0: got %h expected 00000000", rdata0);
        end
        total++;
        if ({en1, cnt1, lmode1, rvalid1, busy1, done1, err1, rdata1} !== 45'd0) begin
            bad++;
            $display("[TB] FAIL reset_dut1: got %h expected 0", {en1, cnt1, lmode1, rvalid1, busy1, done1, err1, rdata1});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode2_stream;
        bit to;
        int errs = 0;
        clear_logs();
        data_base = 32'hA000_0000;
        rready0 = 1'b1;
        start_seq0(2'd2);
        wait_idle0(300, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL m2_timeout: busy still %b expected 0", busy0); end
        total++;
        if (en_log0.size() != 32) begin bad++; $display("[TB] FAIL m2_pulses: got %0d expected 32", en_log0.size()); end
        for (int i = 0; i < en_log0.size(); i++) begin
            total++;
            if (en_log0[i] !== 6'(i)) begin bad++; $display("[TB] FAIL m2_cnt[%0d]: got %0d expected %0d", i, en_log0[i], i); end
        end
        total++;
        if (last_en0 - first_en0 != 31) begin bad++; $display("[TB] FAIL m2_back_to_back: span %0d expected 31", last_en0 - first_en0); end
        total++;
        if (rd_log0.size() != 32) begin bad++; $display("[TB] FAIL m2_words: got %0d expected 32", rd_log0.size()); end
        for (int i = 0; i < rd_log0.size(); i++)
            if (rd_log0[i] !== 32'hA000_0000 + 32'(i)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("[TB] FAIL m2_data: %0d wrong words expected 0", errs); end
        total++;
        if (done_cnt0 != 1) begin bad++; $display("[TB] FAIL m2_done_count: got %0d expected 1", done_cnt0); end
        total++;
        if (done_cyc0 != last_pop0 + 1) begin bad++; $display("[TB] FAIL m2_done_timing: got %0d expected %0d", done_cyc0, last_pop0 + 1); end
        total++;
        if ({busy0, lmode0, cnt0} !== 9'd0) begin bad++; $display("[TB] FAIL m2_idle_after: got %b expected 0", {busy0, lmode0, cnt0}); end
    endtask

    task automatic test_mode1_single;
        bit to;
        clear_logs();
        data_base = 32'h1234_5678;
        rready0 = 1'b1;
        start_seq0(2'd1);
        wait_idle0(50, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL m1_timeout: busy still %b expected 0", busy0); end
        total++;
        if (en_log0.size() != 1) begin bad++; $display("[TB] FAIL m1_pulses: got %0d expected 1", en_log0.size()); end
        else begin
            total++;
            if ({en_log0[0], mode_log0[0]} !== {6'd0, 2'd1}) begin
                bad++;
                $display("[TB] FAIL m1_cnt_mode: got cnt %0d mode %0d expected cnt 0 mode 1", en_log0[0], mode_log0[0]);
            end
        end
        total++;
        if (rd_log0.size() != 1 || rd_log0[0] !== 32'h1234_5678) begin
            bad++;
            $display("[TB] FAIL m1_word: got %0d words first %h expected 1 word 12345678", rd_log0.size(), (rd_log0.size() > 0) ? rd_log0[0] : 32'h0);
        end
        total++;
        if (done_cnt0 != 1) begin bad++; $display("[TB] FAIL m1_done: got %0d expected 1", done_cnt0); end
    endtask

    task automatic test_backpressure;
        bit to;
        int errs = 0;
        clear_logs();
        data_base = 32'hA000_0000;
        rready0 = 1'b0;
        start_seq0(2'd3);
        repeat (20) @(negedge clk);
        total++;
        if (en_log0.size() != 4) begin bad++; $display("[TB] FAIL bp_stall_pulses: got %0d expected 4", en_log0.size()); end
        else begin
            total++;
            if (en_log0[3] !== 6'd3) begin bad++; $display("[TB] FAIL bp_stall_cnt: got %0d expected 3", en_log0[3]); end
        end
        total++;
        if ({rvalid0, busy0, rdata0} !== {2'b11, 32'hA000_0000}) begin
            bad++;
            $display("[TB] FAIL bp_head: got v=%b b=%b d=%h expected v=1 b=1 d=a0000000", rvalid0, busy0, rdata0);
        end
        rready0 = 1'b1;
        @(negedge clk);
        rready0 = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (en_log0.size() != 5 || en_log0[en_log0.size()-1] !== 6'd4) begin
            bad++;
            $display("[TB] FAIL bp_one_credit: got %0d pulses last %0d expected 5 pulses last 4", en_log0.size(), en_log0[en_log0.size()-1]);
        end
        rready0 = 1'b1;
        wait_idle0(300, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL bp_timeout: busy still %b expected 0", busy0); end
        total++;
        if (rd_log0.size() != 32) begin bad++; $display("[TB] FAIL bp_words: got %0d expected 32", rd_log0.size()); end
        for (int i = 0; i < rd_log0.size(); i++)
            if (rd_log0[i] !== 32'hA000_0000 + 32'(i)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("[TB] FAIL bp_data: %0d wrong words expected 0", errs); end
        total++;
        if (max_out0 > 4) begin bad++; $display("[TB] FAIL bp_outstanding: got %0d expected <= 4", max_out0); end
    endtask

    task automatic test_lat1_random;
        int n = 0;
        int errs = 0;
        clear_logs();
        rready1 = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        mode1  = 2'd2;
        @(negedge clk);
        start1 = 1'b0;
        mode1  = 2'd0;
        while (busy1 && n < 3000) begin
            rready1 = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        rready1 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy1 !== 1'b0) begin bad++; $display("[TB] FAIL lat1_timeout: busy %b expected 0", busy1); end
        total++;
        if (rd_log1.size() != 32) begin bad++; $display("[TB] FAIL lat1_words: got %0d expected 32", rd_log1.size()); end
        for (int i = 0; i < rd_log1.size(); i++)
            if (rd_log1[i] !== 32'hA000_0000 + 32'(i)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("[TB] FAIL lat1_data: %0d wrong words expected 0", errs); end
        total++;
        if (max_out1 > 4) begin bad++; $display("[TB] FAIL lat1_outstanding: got %0d expected <= 4", max_out1); end
        total++;
        if (done_cnt1 != 1) begin bad++; $display("[TB] FAIL lat1_done: got %0d expected 1", done_cnt1); end
    endtask

    task automatic test_abort;
        bit to;
        int errs = 0;
        clear_logs();
        data_base = 32'hA000_0000;
        rready0 = 1'b0;
        start_seq0(2'd2);
        repeat (10) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            rready0 = 1'b1;
            @(negedge clk);
            rready0 = 1'b0;
            repeat (3) @(negedge clk);
        end
        total++;
        if (en_log0.size() != 10) begin bad++; $display("[TB] FAIL abort_issued: got %0d expected 10", en_log0.size()); end
        rready0 = 1'b1;
        @(negedge clk);
        rready0 = 1'b0;
        abort0  = 1'b1;
        @(negedge clk);
        abort0  = 1'b0;
        total++;
        if ({rvalid0, busy0, lmode0, en0, cnt0} !== 11'd0) begin
            bad++;
            $display("[TB] FAIL abort_next_cycle: got %b expected 0", {rvalid0, busy0, lmode0, en0, cnt0});
        end
        repeat (4) @(negedge clk);
        total++;
        if (done_cnt0 != 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt0); end
        total++;
        if (en_log0.size() != 10 || rd_log0.size() != 7) begin
            bad++;
            $display("[TB] FAIL abort_counts: got %0d issued %0d popped expected 10 and 7", en_log0.size(), rd_log0.size());
        end
        clear_logs();
        rready0 = 1'b1;
        start_seq0(2'd2);
        wait_idle0(300, to);
        total++;
        if (to || en_log0.size() != 32 || en_log0[0] !== 6'd0) begin
            bad++;
            $display("[TB] FAIL abort_restart: got %0d pulses first %0d expected 32 pulses first 0", en_log0.size(), en_log0[0]);
        end
        for (int i = 0; i < rd_log0.size(); i++)
            if (rd_log0[i] !== 32'hA000_0000 + 32'(i)) errs++;
        total++;
        if (errs != 0 || rd_log0.size() != 32 || done_cnt0 != 1) begin
            bad++;
            $display("[TB] FAIL abort_restart_data: got %0d words %0d wrong %0d done expected 32 0 1", rd_log0.size(), errs, done_cnt0);
        end
    endtask

    task automatic test_err_and_ignore;
        bit to;
        int errs = 0;
        clear_logs();
        data_base = 32'hA000_0000;
        rready0 = 1'b1;
        start_seq0(2'd0);
        total++;
        if ({err0, busy0} !== 2'b10) begin bad++; $display("[TB] FAIL err_pulse: got err=%b busy=%b expected err=1 busy=0", err0, busy0); end
        @(negedge clk);
        total++;
        if (err0 !== 1'b0) begin bad++; $display("[TB] FAIL err_single: got %b expected 0", err0); end
        start_seq0(2'd2);
        repeat (5) @(negedge clk);
        start0 = 1'b1;
        mode0  = 2'd0;
        @(negedge clk);
        mode0  = 2'd1;
        @(negedge clk);
        start0 = 1'b0;
        mode0  = 2'd0;
        wait_idle0(300, to);
        total++;
        if (err_cnt0 != 1) begin bad++; $display("[TB] FAIL busy_start_err: got %0d err pulses expected 1", err_cnt0); end
        for (int i = 0; i < mode_log0.size(); i++)
            if (mode_log0[i] !== 2'd2) errs++;
        total++;
        if (to || en_log0.size() != 32 || errs != 0) begin
            bad++;
            $display("[TB] FAIL busy_start_seq: got %0d pulses %0d bad modes expected 32 and 0", en_log0.size(), errs);
        end
        total++;
        if (rd_log0.size() != 32 || done_cnt0 != 1) begin
            bad++;
            $display("[TB] FAIL busy_start_done: got %0d words %0d done expected 32 and 1", rd_log0.size(), done_cnt0);
        end
    endtask

    task automatic test_async_reset;
        clear_logs();
        data_base = 32'hA000_0000;
        rready0 = 1'b0;
        start_seq0(2'd2);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({en0, cnt0, lmode0, rvalid0, busy0, done0, err0, rdata0} !== 45'd0) begin
            bad++;
            $display("[TB] FAIL async_reset: got %h expected 0", {en0, cnt0, lmode0, rvalid0, busy0, done0, err0, rdata0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({en0, busy0} !== 2'b00) begin bad++; $display("[TB] FAIL async_reset_stays_idle: got %b expected 00", {en0, busy0}); end
    endtask

    initial begin
        start0 = 1'b0; mode0 = 2'd0; abort0 = 1'b0; rready0 = 1'b0;
        start1 = 1'b0; mode1 = 2'd0; abort1 = 1'b0; rready1 = 1'b0;
        data_base = 32'hA000_0000;
        clear_logs();
        test_reset();
        test_mode2_stream();
        test_mode1_single();
        test_backpressure();
        test_lat1_random();
        test_abort();
        test_err_and_ignore();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
